// File: rtl/mem_write_buffer_unit_pkg.sv
// Shared constants for the MEM-stage write buffer:
// FSM encoding, word/doubleword geometry, entry sizing.
package mem_wb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;

   localparam int WORD_LSB = 2;
   localparam int SRAM_W   = 64;

   // One entry is {word address, 32-bit store data}.
   function automatic int entry_w(input int addr_w);
      return addr_w - WORD_LSB + 32;
   endfunction

endpackage

// File: rtl/mem_write_buffer_unit_if.sv
// Request/response bundle between the write buffer
// unit (master) and the SRAM controller (slave).
interface mem_write_buffer_unit_if #(
   parameter int ADDR_W = 32
);
   import mem_wb_pkg::*;

   logic              SRAM_WE;
   logic              SRAM_RE;
   logic [ADDR_W-1:0] SRAM_Address;
   logic [31:0]       SRAM_Write_Data;
   logic              SRAM_Ready;
   logic [SRAM_W-1:0] SRAM_Read_Data;

   modport master (
      output SRAM_WE,
      output SRAM_RE,
      output SRAM_Address,
      output SRAM_Write_Data,
      input  SRAM_Ready,
      input  SRAM_Read_Data
   );

   modport slave (
      input  SRAM_WE,
      input  SRAM_RE,
      input  SRAM_Address,
      input  SRAM_Write_Data,
      output SRAM_Ready,
      output SRAM_Read_Data
   );

endinterface

// File: rtl/mem_write_buffer_unit_fifo.sv
// Circular store buffer with pointers, occupancy and a
// youngest-first word-address search for forwarding.
module write_buffer_fifo
   import mem_wb_pkg::*;
#(
   parameter int  ADDR_W = 32,
   parameter int  DEPTH  = 4,
   localparam int WA     = ADDR_W - WORD_LSB,
   localparam int EW     = entry_w(ADDR_W),
   localparam int PW     = $clog2(DEPTH),
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [WA-1:0] push_addr,
   input  logic [31:0]   push_data,
   input  logic          pop,
   output logic [WA-1:0] head_addr,
   output logic [31:0]   head_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   input  logic [WA-1:0] search_addr,
   output logic          hit,
   output logic [31:0]   hit_data
);

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] idx;
   logic          do_push;
   logic          do_pop;

   assign full      = count == CW'(DEPTH);
   assign empty     = count == '0;
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_addr = mem[rd_ptr][EW-1:32];
   assign head_data = mem[rd_ptr][31:0];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= {push_addr, push_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (CW'(i) < count &&
             mem[idx][EW-1:32] == search_addr) begin
            hit      = 1'b1;
            hit_data = mem[idx][31:0];
         end
      end
   end

endmodule

// File: rtl/mem_write_buffer_unit.sv
// MEM-stage access unit: posted stores, background drain,
// load forwarding or SRAM read with priority over drain.
module mem_write_buffer_unit
   import mem_wb_pkg::*;
#(
   parameter int  ADDR_W     = 32,
   parameter int  WB_DEPTH   = 4,
   parameter int  FORWARD_EN = 1,
   localparam int CW         = $clog2(WB_DEPTH + 1),
   localparam int WA         = ADDR_W - WORD_LSB
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    MEM_R_EN,
   input  logic                    MEM_W_EN,
   input  logic [ADDR_W-1:0]       address,
   input  logic [31:0]             writeData,
   output logic                    ready,
   output logic [31:0]             readData,
   mem_write_buffer_unit_if.master sram,
   output logic [CW-1:0]           wb_count
);

   logic [1:0]        state;
   logic [1:0]        next_state;
   logic              store;
   logic              load;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              hit;
   logic              fwd;
   logic              rd_done;
   logic              go_read;
   logic [WA-1:0]     head_addr;
   logic [31:0]       head_data;
   logic [31:0]       hit_data;
   logic [31:0]       dword;
   logic              we;
   logic              re;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_data;

   assign store   = MEM_W_EN;
   assign load    = MEM_R_EN && !MEM_W_EN;
   assign push    = store && !full;
   assign pop     = state == ST_DRAIN && sram.SRAM_Ready;
   assign rd_done = state == ST_READ && sram.SRAM_Ready;
   assign fwd     = FORWARD_EN != 0 && load && hit;
   // Without forwarding a load must see an empty buffer.
   assign go_read = load && !fwd &&
                    (FORWARD_EN != 0 || empty);

   write_buffer_fifo #(
      .ADDR_W (ADDR_W),
      .DEPTH  (WB_DEPTH)
   ) fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_addr   (address[ADDR_W-1:WORD_LSB]),
      .push_data   (writeData),
      .pop         (pop),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .full        (full),
      .empty       (empty),
      .count       (wb_count),
      .search_addr (address[ADDR_W-1:WORD_LSB]),
      .hit         (hit),
      .hit_data    (hit_data)
   );

   assign dword = address[WORD_LSB] ?
                  sram.SRAM_Read_Data[63:32] :
                  sram.SRAM_Read_Data[31:0];

   always_comb begin
      ready = 1'b1;
      unique case (1'b1)
         store:   ready = !full;
         load:    ready = fwd || rd_done;
         default: ready = 1'b1;
      endcase
   end

   always_comb begin
      readData = '0;
      if (fwd) begin
         readData = hit_data;
      end else if (load && rd_done) begin
         readData = dword;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE: begin
            if (go_read) begin
               next_state = ST_READ;
            end else if (!empty) begin
               next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (sram.SRAM_Ready) begin
               next_state = ST_IDLE;
            end
         end
         ST_READ: begin
            if (sram.SRAM_Ready) begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Head is stable for the whole drain, so latch it once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         we       <= 1'b0;
         re       <= 1'b0;
         req_addr <= '0;
         req_data <= '0;
      end else begin
         state <= next_state;
         if (state == ST_IDLE && next_state == ST_DRAIN) begin
            we       <= 1'b1;
            req_addr <= {head_addr, {WORD_LSB{1'b0}}};
            req_data <= head_data;
         end
         if (state == ST_IDLE && next_state == ST_READ) begin
            re       <= 1'b1;
            req_addr <= address;
         end
         if (state != ST_IDLE && sram.SRAM_Ready) begin
            we <= 1'b0;
            re <= 1'b0;
         end
      end
   end

   assign sram.SRAM_WE         = we;
   assign sram.SRAM_RE         = re;
   assign sram.SRAM_Address    = req_addr;
   assign sram.SRAM_Write_Data = req_data;

endmodule

// File: tb/tb_mem_write_buffer_unit.sv
// Two units (forwarding on / off) driven against an ordered-list
// model of the buffer plus a latency-randomised SRAM controller.
module tb_mem_write_buffer_unit;

   localparam int AW = 32;
   localparam int D  = 4;
   localparam int M_IDLE  = 0;
   localparam int M_DRAIN = 1;
   localparam int M_READ  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        r_en   [2];
   logic        w_en   [2];
   logic [31:0] addr   [2];
   logic [31:0] wdat   [2];
   logic        rdy    [2];
   logic [31:0] rdata  [2];
   logic [2:0]  cnt    [2];
   logic        s_we   [2];
   logic        s_re   [2];
   logic [31:0] s_addr [2];
   logic [31:0] s_wd   [2];
   logic        s_rdy  [2];
   logic [63:0] s_rd   [2];

   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g
      mem_write_buffer_unit_if #(.ADDR_W(AW)) sif ();
      mem_write_buffer_unit #(
         .ADDR_W     (AW),
         .WB_DEPTH   (D),
         .FORWARD_EN (k == 0 ? 1 : 0)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .MEM_R_EN  (r_en[k]),
         .MEM_W_EN  (w_en[k]),
         .address   (addr[k]),
         .writeData (wdat[k]),
         .ready     (rdy[k]),
         .readData  (rdata[k]),
         .sram      (sif),
         .wb_count  (cnt[k])
      );
      assign s_we[k]            = sif.SRAM_WE;
      assign s_re[k]            = sif.SRAM_RE;
      assign s_addr[k]          = sif.SRAM_Address;
      assign s_wd[k]            = sif.SRAM_Write_Data;
      assign sif.SRAM_Ready     = s_rdy[k];
      assign sif.SRAM_Read_Data = s_rd[k];
   end

   int nvec = 0;
   int nerr = 0;

   // Model: buffer as ordered list, index 0 oldest.
   logic [63:0] mbuf [2][8];
   int          msz  [2];
   int          mode [2];
   logic [31:0] m_a  [2];
   logic [31:0] m_d  [2];

   bit          e_ready [2];
   bit          n_push  [2];
   bit          n_pop   [2];
   int          n_mode  [2];
   logic [31:0] n_a     [2];
   logic [31:0] n_d     [2];
   logic [63:0] n_ent   [2];

   int          ccnt [2];
   int          clat [2];
   int          lat_fix;
   bit          pin;
   logic [63:0] pin_val;
   int          first_req [2];
   logic [63:0] wlog [$];

   logic [31:0] c_rdata [2];
   logic        c_re    [2];
   logic [2:0]  c_cnt   [2];

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic settle_check();
      #1;
      for (int k = 0; k < 2; k++) begin
         bit st, ld, full, empty, hit, fwd, done;
         logic [31:0] fd, sel, er;
         st    = w_en[k];
         ld    = r_en[k] && !w_en[k];
         full  = msz[k] == D;
         empty = msz[k] == 0;
         hit   = 0;
         fd    = '0;
         for (int i = 0; i < msz[k]; i++) begin
            if (mbuf[k][i][63:34] == addr[k][31:2]) begin
               hit = 1;
               fd  = mbuf[k][i][31:0];
            end
         end
         fwd  = (k == 0) && ld && hit;
         done = mode[k] == M_READ && s_rdy[k];
         sel  = addr[k][2] ? s_rd[k][63:32] : s_rd[k][31:0];
         e_ready[k] = st ? !full : (ld ? (fwd || done) : 1'b1);
         er = fwd ? fd : ((ld && done) ? sel : 32'h0);
         chk($sformatf("k%0d ready", k), rdy[k], e_ready[k]);
         chk($sformatf("k%0d readData", k), rdata[k], er);
         chk($sformatf("k%0d SRAM_WE", k), s_we[k],
             mode[k] == M_DRAIN);
         chk($sformatf("k%0d SRAM_RE", k), s_re[k],
             mode[k] == M_READ);
         chk($sformatf("k%0d SRAM_Address", k), s_addr[k], m_a[k]);
         chk($sformatf("k%0d SRAM_Write_Data", k), s_wd[k], m_d[k]);
         chk($sformatf("k%0d wb_count", k), cnt[k], msz[k]);
         n_pop[k]  = mode[k] == M_DRAIN && s_rdy[k];
         n_push[k] = st && !full;
         n_ent[k]  = {addr[k], wdat[k]};
         n_mode[k] = mode[k];
         n_a[k]    = m_a[k];
         n_d[k]    = m_d[k];
         if (mode[k] == M_IDLE) begin
            if (ld && !fwd && (k == 0 || empty)) begin
               n_mode[k] = M_READ;
               n_a[k]    = addr[k];
            end else if (!empty) begin
               n_mode[k] = M_DRAIN;
               n_a[k]    = {mbuf[k][0][63:34], 2'b00};
               n_d[k]    = mbuf[k][0][31:0];
            end
         end else if (s_rdy[k]) begin
            n_mode[k] = M_IDLE;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            msz[k]  = 0;
            mode[k] = M_IDLE;
            m_a[k]  = '0;
            m_d[k]  = '0;
         end else begin
            if (n_pop[k]) begin
               for (int i = 0; i < 7; i++) mbuf[k][i] = mbuf[k][i+1];
               msz[k]--;
            end
            if (n_push[k]) begin
               mbuf[k][msz[k]] = n_ent[k];
               msz[k]++;
            end
            mode[k] = n_mode[k];
            m_a[k]  = n_a[k];
            m_d[k]  = n_d[k];
         end
         // SRAM controller: one-cycle done pulse after clat cycles.
         if (rst || s_rdy[k]) begin
            s_rdy[k] = 1'b0;
            ccnt[k]  = 0;
         end else if (s_we[k] || s_re[k]) begin
            if (ccnt[k] == 0) begin
               clat[k] = lat_fix != 0 ? lat_fix : $urandom_range(1, 5);
               if (first_req[k] == 0) first_req[k] = s_we[k] ? 1 : 2;
            end
            ccnt[k]++;
            if (ccnt[k] >= clat[k]) begin
               s_rdy[k] = 1'b1;
               s_rd[k]  = pin ? pin_val : {$urandom, $urandom};
               if (s_we[k] && k == 0) wlog.push_back({s_addr[k], s_wd[k]});
            end
         end else begin
            ccnt[k] = 0;
         end
      end
   endtask

   task automatic op(input int k, input bit r, input bit w,
                     input logic [31:0] a, input logic [31:0] d,
                     output int waited);
      r_en[k] = r;
      w_en[k] = w;
      addr[k] = a;
      wdat[k] = d;
      waited  = 0;
      for (int n = 0; n < 100; n++) begin
         settle_check();
         if (e_ready[k]) begin
            c_rdata[k] = rdata[k];
            c_re[k]    = s_re[k];
            c_cnt[k]   = cnt[k];
            tick();
            r_en[k] = 1'b0;
            w_en[k] = 1'b0;
            return;
         end
         waited++;
         tick();
      end
      nvec++;
      nerr++;
      $display("FAIL k%0d op timeout: got no ready required ready", k);
      r_en[k] = 1'b0;
      w_en[k] = 1'b0;
   endtask

   task automatic drain(input int k);
      for (int n = 0; n < 200; n++) begin
         if (msz[k] == 0 && mode[k] == M_IDLE) return;
         settle_check();
         tick();
      end
      nvec++;
      nerr++;
      $display("FAIL k%0d drain timeout: got wb_count %0d required 0",
               k, msz[k]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1);
   end

   initial begin
      int w;
      int ws [5];
      bit seen;
      bit busy  [2];
      int stall [2];
      bit abort;

      rst     = 1'b1;
      lat_fix = 1;
      pin     = 0;
      pin_val = '0;
      for (int k = 0; k < 2; k++) begin
         r_en[k] = 0; w_en[k] = 0; addr[k] = '0; wdat[k] = '0;
         s_rdy[k] = 0; s_rd[k] = '0; ccnt[k] = 0; clat[k] = 1;
         msz[k] = 0; mode[k] = M_IDLE; m_a[k] = '0; m_d[k] = '0;
         first_req[k] = 0; busy[k] = 0; stall[k] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      settle_check();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("k%0d reset wb_count", k), cnt[k], 0);
         chk($sformatf("k%0d reset SRAM_WE", k), s_we[k], 0);
         chk($sformatf("k%0d reset SRAM_RE", k), s_re[k], 0);
         chk($sformatf("k%0d reset SRAM_Address", k), s_addr[k], 0);
         chk($sformatf("k%0d reset ready", k), rdy[k], 1);
         chk($sformatf("k%0d reset readData", k), rdata[k], 0);
      end
      tick();

      // Single store then drain.
      op(0, 0, 1, 32'h400, 32'hDEADBEEF, w);
      chk("store0 wait", w, 0);
      settle_check();
      chk("store0 wb_count", cnt[0], 1);
      tick();
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         settle_check();
         if (s_we[0]) begin
            seen = 1;
            chk("drain0 address", s_addr[0], 32'h400);
            chk("drain0 data", s_wd[0], 32'hDEADBEEF);
         end
         tick();
      end
      chk("drain0 seen", seen, 1);
      drain(0);
      settle_check();
      chk("drain0 wb_count", cnt[0], 0);
      tick();

      // Five stores into a 4-deep buffer, slow SRAM.
      lat_fix = 5;
      wlog.delete();
      for (int i = 0; i < 5; i++) begin
         op(0, 0, 1, 32'h500 + 32'(4 * i), 32'h100 + 32'(i), ws[i]);
      end
      for (int i = 0; i < 4; i++) chk($sformatf("burst%0d wait", i), ws[i], 0);
      chk("burst4 stalled", ws[4] > 0, 1);
      drain(0);
      chk("burst write count", wlog.size(), 5);
      for (int i = 0; i < 5 && i < wlog.size(); i++) begin
         chk($sformatf("burst order %0d", i), wlog[i],
             {32'h500 + 32'(4 * i), 32'h100 + 32'(i)});
      end

      // Youngest-match forwarding.
      lat_fix = 1;
      op(0, 0, 1, 32'h404, 32'd1, w);
      op(0, 0, 1, 32'h404, 32'd2, w);
      op(0, 1, 0, 32'h404, 32'h0, w);
      chk("fwd wait", w, 0);
      chk("fwd readData", c_rdata[0], 32'd2);
      chk("fwd no SRAM_RE", c_re[0], 0);
      drain(0);

      // Load miss with a non-empty buffer, forwarding on.
      lat_fix = 5;
      pin = 1;
      pin_val = 64'h11112222_33334444;
      first_req[0] = 0;
      op(0, 0, 1, 32'h400, 32'hAA, w);
      op(0, 1, 0, 32'h40C, 32'h0, w);
      chk("miss fwd1 readData", c_rdata[0], 32'h11112222);
      chk("miss fwd1 read first", first_req[0], 2);
      chk("miss fwd1 wb_count", c_cnt[0], 1);
      drain(0);

      // Same with forwarding off: drain first.
      first_req[1] = 0;
      op(1, 0, 1, 32'h400, 32'hAA, w);
      op(1, 1, 0, 32'h40C, 32'h0, w);
      chk("miss fwd0 readData", c_rdata[1], 32'h11112222);
      chk("miss fwd0 drain first", first_req[1], 1);
      chk("miss fwd0 wb_count", c_cnt[1], 0);
      drain(1);
      pin = 0;

      // Reset while draining with three entries.
      op(0, 0, 1, 32'h600, 32'h1, w);
      op(0, 0, 1, 32'h604, 32'h2, w);
      op(0, 0, 1, 32'h608, 32'h3, w);
      settle_check();
      chk("pre-reset SRAM_WE", s_we[0], 1);
      chk("pre-reset wb_count", cnt[0], 3);
      tick();
      rst = 1'b1;
      settle_check();
      tick();
      rst = 1'b0;
      settle_check();
      chk("post-reset wb_count", cnt[0], 0);
      chk("post-reset SRAM_WE", s_we[0], 0);
      chk("post-reset SRAM_RE", s_re[0], 0);
      chk("post-reset ready", rdy[0], 1);
      tick();

      // Random traffic on both units.
      lat_fix = 0;
      abort = 0;
      for (int c = 0; c < 3000 && !abort; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!busy[k]) begin
               int x;
               x = $urandom_range(0, 9);
               addr[k] = 32'h400 + 32'($urandom_range(0, 7) << 2)
                         + 32'($urandom_range(0, 3));
               wdat[k] = $urandom;
               r_en[k] = x >= 6;
               w_en[k] = (x >= 3 && x < 6) || x == 9;
               busy[k] = x >= 3;
            end
         end
         rst = $urandom_range(0, 399) == 0;
         settle_check();
         for (int k = 0; k < 2; k++) begin
            if (busy[k]) begin
               if (e_ready[k]) begin
                  busy[k]  = 0;
                  stall[k] = 0;
               end else begin
                  stall[k]++;
                  if (stall[k] > 150) begin
                     nvec++;
                     nerr++;
                     $display("FAIL k%0d stall: got ready low required ready", k);
                     abort = 1;
                  end
               end
            end
         end
         tick();
         for (int k = 0; k < 2; k++) begin
            if (!busy[k]) begin
               r_en[k] = 0;
               w_en[k] = 0;
            end
         end
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
